match_event_counter: RTL and testbench
======================================

# match_event_counter

Downstream consumer of the 1011 sequence detector's `detector_out` pulse stream. Counts detection events over a programmable window of clock cycles and publishes each window's total through a one-deep valid/ready output register. Flags results lost to a stalled consumer. Gives the rest of the design a rate measurement instead of raw single-cycle pulses.

## Interface
- `CNT_W`, 8: width of the event count and result.
- `WIN_W`, 16: width of the window length.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `detector_in`  in  1  detection pulse from the sequence detector (Moore output).
- `enable`  in  1  high = measure continuously; low = idle.
- `window_len`  in  WIN_W  window length in cycles; sampled at each window start.
- `count_out`  out  CNT_W  published window count.
- `count_valid`  out  1  `count_out` holds an unconsumed result.
- `count_ready`  in  1  consumer accepts `count_out` at a rising edge when `count_valid`=1.
- `overrun`  out  1  sticky: an unconsumed result was overwritten.
- `ovr_clr`  in  1  synchronous one-cycle clear of `overrun`.
- `irq_thresh`  in  CNT_W  threshold; exists only with `MATCH_CNT_IRQ_EN`.
- `irq`  out  1  threshold flag; exists only with `MATCH_CNT_IRQ_EN`.

## Operation
- **Event definition:** a rising edge of `detector_in`, which means `detector_in`=1 while the registered previous value `prev`=0.
  - `prev` updates every cycle, in all states.
  - A level held high for several cycles counts once.
- **FSM states:**
  - IDLE: not measuring.
  - RUN: measuring.
- **Transitions:**
  - IDLE→RUN on a clock edge where `enable`=1. At that edge: `acc`<=0, `win_cnt`<=0, `win_len_q`<=max(`window_len`,1).
  - RUN→IDLE on any edge where `enable`=0. The partial window is discarded, `acc` and `win_cnt` are cleared, and no result is published.
- **In RUN, each edge:**
  - `acc` increments on an event, saturating at 2^CNT_W−1.
  - `win_cnt` increments.
- **Window end** (RUN and `win_cnt`=`win_len_q`−1):
  - `count_out` <= `acc` + event-this-cycle, saturated. The final cycle's event belongs to the ending window.
  - `count_valid`<=1.
  - `acc`<=0, `win_cnt`<=0.
  - `win_len_q` re-samples `window_len`, with 0 treated as 1.
  - The FSM stays in RUN.
- **Handshake:**
  - `count_valid` falls at the edge where `count_valid`=1 and `count_ready`=1, unless a window end occurs on the same edge.
  - `count_out` is stable while `count_valid`=1 and not accepted.
- **Simultaneous accept and window end:** the new value loads, `count_valid` stays 1, and `overrun` is not set.
- **Overrun:** a window end while `count_valid`=1 and `count_ready`=0 overwrites `count_out` with the newer result and sets `overrun`.
  - `overrun` stays set until `ovr_clr` or `reset`.
  - If set and clear occur on the same edge, set wins.
- **Leaving RUN:** a held result survives RUN→IDLE and stays valid until accepted.
- **Reset values:** `count_out`=0, `count_valid`=0, `overrun`=0, `irq`=0, state IDLE, `acc`=0, `win_cnt`=0, `prev`=0.
- **Reset mid-operation:** all of the above is forced immediately and asynchronously; any pending result is lost.

## Timing
- Event-to-accumulator latency: 1 cycle.
- A window of length N covers N consecutive RUN cycles, starting on the cycle after the IDLE→RUN edge.
- `count_valid` rises on the edge ending the window.
- Back-to-back windows have no gap cycles.
- All outputs are registered. There is no combinational path from `count_ready` to any output.

## Configuration
- Macro: `MATCH_CNT_IRQ_EN`.
- **Defined:** `irq_thresh` and `irq` ports exist.
  - `irq` is registered, asserted on the edge that publishes a result ≥ `irq_thresh`.
  - `irq` holds while that result remains valid.
  - `irq` clears when the result is accepted or replaced by a result below the threshold.
  - Reset value 0.
- **Undefined:** both ports and the comparator are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - the state encoding constants `MC_IDLE`=1'b0 and `MC_RUN`=1'b1;
  - default values for `CNT_W` and `WIN_W`.
- One natural sub-module: `rise_detect`. It holds the `prev` register plus the edge output and is reusable for other pulse consumers.
- Window counter, accumulator and output register stay in the top module.

## Test plan
- **Basic count:** `window_len`=16, `enable`=1, drive `detector_in` pulses at RUN cycles 2, 7 and 12, `count_ready`=1 → `count_out`=3, `count_valid` high exactly one cycle after the window-end edge.
- **Boundary event:** pulse on cycle 15 of a 16-cycle window and on cycle 0 of the next → first result 1, second result 1.
- **Held level:** `detector_in` held high for 5 cycles → counts 1. With `CNT_W`=2, drive 5 separate pulses in one window → `count_out`=3 (saturated).
- **Overrun and clear:** `count_ready`=0 across two windows with counts 2 then 4 → `count_out`=4, `overrun`=1. Then `ovr_clr` pulse → `overrun`=0. Repeat with `count_ready`=1 on the window-end edge → `overrun` stays 0 and `count_valid` stays 1.
- **Disable and reset mid-window:**
  - Drop `enable` at cycle 8 of 16 with 3 events counted → no result published, and a previously held result stays valid.
  - Assert `reset` mid-window → all outputs 0 immediately.
- **`window_len`=0 and IRQ:**
  - `window_len`=0 → a result every cycle.
  - With `MATCH_CNT_IRQ_EN`, `irq_thresh`=2, counts of 1 then 2 → `irq` 0 then 1, and `irq` clears on accept.

Source files
------------

// File: rtl/match_event_counter_pkg.sv
// Shared definitions for the match event counter: FSM encoding and default widths.
package match_event_counter_pkg;
   localparam int   MC_CNT_W_DEF = 8;
   localparam int   MC_WIN_W_DEF = 16;
   localparam logic MC_IDLE      = 1'b0;
   localparam logic MC_RUN       = 1'b1;

   typedef enum logic {
      ST_IDLE = MC_IDLE,
      ST_RUN  = MC_RUN
   } mc_state_t;
endpackage

// File: rtl/match_event_counter_if.sv
// Result bus for the match event counter: one-deep valid/ready window count.
interface match_event_counter_if
   import match_event_counter_pkg::*;
#(
   parameter int CNT_W = MC_CNT_W_DEF
);
   logic [CNT_W-1:0] count_out;
   logic             count_valid;
   logic             count_ready;

   modport master (output count_out, output count_valid, input count_ready);
   modport slave  (input count_out, input count_valid, output count_ready);
endinterface

// File: rtl/match_event_counter_rise_detect.sv
// Rising-edge detector: registers the previous level, flags level=1 after prev=0.
module rise_detect (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic rise
);
   logic prev;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) prev <= 1'b0;
      else       prev <= level;
   end

   assign rise = level & ~prev;
endmodule

// File: rtl/match_event_counter.sv
// Counts detector rising edges per programmable window; result registered on the window-end edge.
// One-deep valid/ready output; a stalled result is overwritten and flagged in overrun. Option: MATCH_CNT_IRQ_EN.
module match_event_counter
   import match_event_counter_pkg::*;
#(
   parameter int CNT_W = MC_CNT_W_DEF,
   parameter int WIN_W = MC_WIN_W_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   detector_in,
   input  logic                   enable,
   input  logic [WIN_W-1:0]       window_len,
   match_event_counter_if.master  res,
   output logic                   overrun,
   input  logic                   ovr_clr
`ifdef MATCH_CNT_IRQ_EN
   ,
   input  logic [CNT_W-1:0]       irq_thresh,
   output logic                   irq
`endif
);
   localparam logic [CNT_W-1:0] ACC_MAX = '1;

   mc_state_t        state, state_nxt;
   logic             event_now;
   logic             win_end;
   logic [CNT_W-1:0] acc, acc_nxt;
   logic [WIN_W-1:0] win_cnt, win_len_q, len_eff;
   logic [CNT_W-1:0] out_q;
   logic             valid_q;

   rise_detect u_rise (
      .clock (clock),
      .reset (reset),
      .level (detector_in),
      .rise  (event_now)
   );

   assign acc_nxt = (event_now && acc != ACC_MAX) ? acc + CNT_W'(1) : acc;
   assign len_eff = (window_len == '0) ? WIN_W'(1) : window_len;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Dropping enable takes priority over a window end on the same edge.
   always_comb begin
      state_nxt = state;
      win_end   = 1'b0;
      case (state)
         ST_IDLE: if (enable) state_nxt = ST_RUN;
         ST_RUN: begin
            if (!enable)
               state_nxt = ST_IDLE;
            else if (win_cnt == win_len_q - WIN_W'(1))
               win_end = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc       <= '0;
         win_cnt   <= '0;
         win_len_q <= WIN_W'(1);
      end else if (state == ST_IDLE) begin
         acc     <= '0;
         win_cnt <= '0;
         if (enable) win_len_q <= len_eff;
      end else if (!enable || win_end) begin
         acc     <= '0;
         win_cnt <= '0;
         if (win_end) win_len_q <= len_eff;
      end else begin
         acc     <= acc_nxt;
         win_cnt <= win_cnt + WIN_W'(1);
      end
   end

   // A window end loads the new result even when the old one is accepted on the same edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_q   <= '0;
         valid_q <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (win_end) begin
            out_q   <= acc_nxt;
            valid_q <= 1'b1;
         end else if (valid_q && res.count_ready) begin
            valid_q <= 1'b0;
         end
         if (win_end && valid_q && !res.count_ready) overrun <= 1'b1;
         else if (ovr_clr)                          overrun <= 1'b0;
      end
   end

   assign res.count_out   = out_q;
   assign res.count_valid = valid_q;

`ifdef MATCH_CNT_IRQ_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                             irq <= 1'b0;
      else if (win_end)                      irq <= (acc_nxt >= irq_thresh);
      else if (valid_q && res.count_ready)   irq <= 1'b0;
   end
`endif
endmodule

// File: tb/tb_match_event_counter.sv
// Directed bench for match_event_counter (8-bit main instance plus a 2-bit saturation instance).
module tb_match_event_counter;
   logic        clock;
   logic        reset;
   logic        detector_in;
   logic        enable;
   logic [15:0] window_len;
   logic        overrun, overrun2;
   logic        ovr_clr;
   logic        ready2;
`ifdef MATCH_CNT_IRQ_EN
   logic [7:0]  irq_thresh;
   logic [1:0]  irq_thresh2;
   logic        irq, irq2;
`endif

   int checks = 0;
   int errors = 0;

   match_event_counter_if #(.CNT_W(8)) bus ();
   match_event_counter_if #(.CNT_W(2)) bus2 ();

   match_event_counter #(.CNT_W(8), .WIN_W(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .detector_in (detector_in),
      .enable      (enable),
      .window_len  (window_len),
      .res         (bus),
      .overrun     (overrun),
      .ovr_clr     (ovr_clr)
`ifdef MATCH_CNT_IRQ_EN
      ,
      .irq_thresh  (irq_thresh),
      .irq         (irq)
`endif
   );

   match_event_counter #(.CNT_W(2), .WIN_W(16)) dut2 (
      .clock       (clock),
      .reset       (reset),
      .detector_in (detector_in),
      .enable      (enable),
      .window_len  (window_len),
      .res         (bus2),
      .overrun     (overrun2),
      .ovr_clr     (ovr_clr)
`ifdef MATCH_CNT_IRQ_EN
      ,
      .irq_thresh  (irq_thresh2),
      .irq         (irq2)
`endif
   );

   assign bus2.count_ready = ready2;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive n cycles; bit k of each pattern applies during the k-th cycle.
   task automatic cyc(input int n, input logic [15:0] det, input logic [15:0] rdy,
                      input logic [15:0] clr);
      for (int k = 0; k < n; k++) begin
         detector_in     = det[k];
         bus.count_ready = rdy[k];
         ovr_clr         = clr[k];
         @(posedge clock);
         #1;
      end
      detector_in = 1'b0;
      ovr_clr     = 1'b0;
   endtask

   initial begin
      reset           = 1'b1;
      enable          = 1'b0;
      window_len      = 16'd16;
      detector_in     = 1'b0;
      bus.count_ready = 1'b0;
      ovr_clr         = 1'b0;
      ready2          = 1'b1;
`ifdef MATCH_CNT_IRQ_EN
      irq_thresh      = 8'd2;
      irq_thresh2     = 2'd2;
`endif
      @(posedge clock);
      #1;
      chk("rst_out",     bus.count_out,   0);
      chk("rst_valid",   bus.count_valid, 0);
      chk("rst_overrun", overrun,         0);
      reset = 1'b0;
      cyc(1, 16'h0000, 16'h0000, 16'h0000);

      // Basic count: pulses at cycles 2, 7, 12.
      enable = 1'b1;
      cyc(1, 16'h0000, 16'hFFFF, 16'h0000);
      cyc(16, 16'h1084, 16'hFFFF, 16'h0000);
      chk("basic_valid", bus.count_valid, 1);
      chk("basic_out",   bus.count_out,   3);

      // Event on the first cycle of a window, then on the last cycle of the next.
      cyc(1, 16'h0001, 16'hFFFF, 16'h0000);
      chk("accept_drop", bus.count_valid, 0);
      cyc(15, 16'h0000, 16'hFFFF, 16'h0000);
      chk("first_cyc_out",   bus.count_out,   1);
      chk("first_cyc_valid", bus.count_valid, 1);
      cyc(16, 16'h8000, 16'hFFFF, 16'h0000);
      chk("last_cyc_out", bus.count_out, 1);

      // Held level counts once; five pulses saturate the 2-bit instance.
      cyc(16, 16'h00F8, 16'hFFFF, 16'h0000);
      chk("held_out", bus.count_out, 1);
      cyc(16, 16'h0155, 16'hFFFF, 16'h0000);
      chk("five_out",  bus.count_out,  5);
      chk("sat_out",   bus2.count_out, 3);
      chk("sat_valid", bus2.count_valid, 1);

      // Stalled consumer across two windows (2 then 4 events).
      cyc(16, 16'h0022, 16'h0001, 16'h0000);
      chk("stall1_out", bus.count_out, 2);
      chk("stall1_ovr", overrun,       0);
      cyc(8, 16'h00AA, 16'h0000, 16'h0000);
      chk("stable_out",   bus.count_out,   2);
      chk("stable_valid", bus.count_valid, 1);
      cyc(8, 16'h0000, 16'h0000, 16'h0000);
      chk("ovr_out",   bus.count_out,   4);
      chk("ovr_set",   overrun,         1);
      chk("ovr_valid", bus.count_valid, 1);
      cyc(1, 16'h0000, 16'h0000, 16'h0001);
      chk("ovr_clr", overrun, 0);
      // Clear and set on the same edge: set wins.
      cyc(15, 16'h0002, 16'h0000, 16'h4000);
      chk("set_wins", overrun,       1);
      chk("sw_out",   bus.count_out, 1);

      // Accept coinciding with a window end.
      cyc(16, 16'h0510, 16'h8000, 16'h0001);
      chk("sim_out",   bus.count_out,   3);
      chk("sim_valid", bus.count_valid, 1);
      chk("sim_ovr",   overrun,         0);

      // Drop enable mid-window with 3 events counted; held result survives.
      cyc(8, 16'h002A, 16'h0000, 16'h0000);
      enable = 1'b0;
      cyc(13, 16'h0000, 16'h0000, 16'h0000);
      chk("dis_valid", bus.count_valid, 1);
      chk("dis_out",   bus.count_out,   3);
      chk("dis_ovr",   overrun,         0);
      cyc(1, 16'h0000, 16'h0001, 16'h0000);
      chk("dis_acc", bus.count_valid, 0);

      // Restart: discarded partial must not leak into the new window.
      enable = 1'b1;
      cyc(1, 16'h0000, 16'h0000, 16'h0000);
      cyc(16, 16'h0040, 16'hFFFF, 16'h0000);
      chk("restart_out", bus.count_out, 1);

      // window_len = 0 behaves as a 1-cycle window.
      enable = 1'b0;
      cyc(1, 16'h0000, 16'hFFFF, 16'h0000);
      window_len = 16'd0;
      enable     = 1'b1;
      cyc(1, 16'h0000, 16'h0000, 16'h0000);
      cyc(1, 16'h0001, 16'h0000, 16'h0000);
      chk("len0_a_out",   bus.count_out,   1);
      chk("len0_a_valid", bus.count_valid, 1);
      cyc(1, 16'h0000, 16'h0000, 16'h0000);
      chk("len0_b_out", bus.count_out, 0);
      chk("len0_b_ovr", overrun,       1);
      cyc(1, 16'h0001, 16'h0000, 16'h0000);
      chk("len0_c_out", bus.count_out, 1);

      // Asynchronous reset between clock edges.
      #3;
      reset = 1'b1;
      #1;
      chk("arst_out",    bus.count_out,   0);
      chk("arst_valid",  bus.count_valid, 0);
      chk("arst_ovr",    overrun,         0);
      chk("arst_valid2", bus2.count_valid, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      enable = 1'b0;

`ifdef MATCH_CNT_IRQ_EN
      chk("irq_rst", irq, 0);
      window_len = 16'd16;
      enable     = 1'b1;
      cyc(1, 16'h0000, 16'h0000, 16'h0000);
      cyc(16, 16'h0008, 16'h0000, 16'h0000);
      chk("irq_below", irq, 0);
      cyc(16, 16'h0108, 16'h0001, 16'h0000);
      chk("irq_at", irq, 1);
      cyc(1, 16'h0000, 16'h0001, 16'h0000);
      chk("irq_clr", irq, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
